// File: rtl/spu_sm_pkg.sv
// Shared definitions for the SPU row-summation sequencer: FSM encoding,
// default buffer/length widths and the adder-tree accumulator width.
package spu_sm_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int LEN_W_DEF  = 9;
  localparam int ACC_W      = 20;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_CAPT,
    ST_OUT
  } state_t;

endpackage

// File: rtl/spu_sm_grp_addr_gen.sv
// Group address/count generator: loads base and length, steps one group per
// cycle and flags the last group of the row.
module spu_sm_grp_addr_gen #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 9
) (
  input  logic              core_clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] addr,
  output logic              last
);

  logic [LEN_W-1:0] cnt;
  logic [LEN_W-1:0] len_q;

  // Counter is LEN_W wide so a 256-group row still reaches len-1 cleanly;
  // the address simply wraps at 2^ADDR_W.
  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      addr  <= '0;
      cnt   <= '0;
      len_q <= '0;
    end else if (load) begin
      addr  <= base;
      cnt   <= '0;
      len_q <= len;
    end else if (step) begin
      addr <= addr + ADDR_W'(1);
      cnt  <= cnt + LEN_W'(1);
    end
  end

  assign last = (cnt == (len_q - LEN_W'(1)));

endmodule

// File: rtl/spu_sm_sum_ctrl.sv
// Row-summation sequencer: streams group-buffer reads into an external adder
// tree, captures the accumulated row sum and offers it on a valid/ready port.
module spu_sm_sum_ctrl
  import spu_sm_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int LEN_W  = LEN_W_DEF
) (
  input  logic              core_clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              abort,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              at_en,
  input  logic [ACC_W-1:0]  at_sum,
  output logic              busy,
  output logic              sum_valid,
  input  logic              sum_ready,
  output logic [ACC_W-1:0]  sum_data
);

  state_t state;
  logic   gen_load;
  logic   gen_step;
  logic   gen_last;

  assign gen_load = (state == ST_IDLE) && cfg_start && (cfg_len != '0) && !abort;
  assign gen_step = (state == ST_FETCH) && !gen_last && !abort;

  spu_sm_grp_addr_gen #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_addr_gen (
    .core_clk (core_clk),
    .rst_n    (rst_n),
    .load     (gen_load),
    .step     (gen_step),
    .base     (cfg_base),
    .len      (cfg_len),
    .addr     (rd_addr),
    .last     (gen_last)
  );

  always_ff @(posedge core_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      rd_en     <= 1'b0;
      at_en     <= 1'b0;
      busy      <= 1'b0;
      sum_valid <= 1'b0;
      sum_data  <= '0;
    end else if (abort) begin
      state     <= ST_IDLE;
      rd_en     <= 1'b0;
      at_en     <= 1'b0;
      busy      <= 1'b0;
      sum_valid <= 1'b0;
    end else begin
      // Read data arrives one cycle after rd_en, so the tree enable trails it.
      at_en <= rd_en;
      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            busy <= 1'b1;
            if (cfg_len != '0) begin
              state <= ST_FETCH;
              rd_en <= 1'b1;
            end else begin
              state     <= ST_OUT;
              sum_data  <= '0;
              sum_valid <= 1'b1;
            end
          end
        end
        ST_FETCH: begin
          if (gen_last) begin
            state <= ST_DRAIN;
            rd_en <= 1'b0;
          end
        end
        ST_DRAIN: state <= ST_CAPT;
        ST_CAPT: begin
          // at_en is low here, so the tree clears on the same edge we sample it.
          state     <= ST_OUT;
          sum_data  <= at_sum;
          sum_valid <= 1'b1;
        end
        ST_OUT: begin
          if (sum_ready) begin
            state     <= ST_IDLE;
            sum_valid <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/spu_sm_sum_ctrl.md
SPU_SM_SUM_CTRL -- requirements
Module: spu_sm_sum_ctrl

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the group-buffer address width.
REQ-002 Parameter LEN_W, default 9, SHALL set the length field width, allowing up to 256 groups.
REQ-003 core_clk  input  1  SHALL be the clock; all state updates occur on its rising edge.
REQ-004 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-005 cfg_start  input  1  SHALL request a row summation; it is sampled only in IDLE.
REQ-006 cfg_base  input  ADDR_W  SHALL give the first group address, sampled with cfg_start.
REQ-007 cfg_len  input  LEN_W  SHALL give the number of 4-byte groups (0..256), sampled with cfg_start.
REQ-008 abort  input  1  SHALL be a synchronous cancel of the current operation.
REQ-009 rd_en  output  1  SHALL be the group-buffer read strobe; buffer read data is valid one cycle after rd_en.
REQ-010 rd_addr  output  ADDR_W  SHALL be the group-buffer read address.
REQ-011 at_en  output  1  SHALL drive the adder-tree accumulate enable; the adder tree clears when at_en=0.
REQ-012 at_sum  input  20  SHALL carry the adder-tree accumulator value.
REQ-013 busy  output  1  SHALL be 1 whenever the state is not IDLE.
REQ-014 sum_valid / sum_ready  output / input  1 / 1  SHALL form the result handshake.
REQ-015 sum_data  output  20  SHALL carry the row sum; it is stable while sum_valid=1.

Function
REQ-016 FSM states SHALL be IDLE, FETCH, DRAIN, CAPT, OUT.
REQ-017 IDLE SHALL go to FETCH when cfg_start=1 and cfg_len>0; it SHALL latch base and len and clear the group counter.
REQ-018 IDLE with cfg_start=1 and cfg_len=0 SHALL go directly to OUT with sum_data=0, issuing no reads and no at_en.
REQ-019 FETCH SHALL assert rd_en with rd_addr=base+k (mod 2^ADDR_W) for k=0..len-1, one group per cycle.
REQ-020 After the cycle with k=len-1, FETCH SHALL go to DRAIN.
REQ-021 at_en SHALL be rd_en delayed by one cycle (registered), so it is high exactly len cycles, ending in DRAIN.
REQ-022 DRAIN SHALL last 1 cycle and then go to CAPT.
REQ-023 In CAPT, at_en=0; sum_data SHALL latch at_sum on the CAPT exit edge, while the adder tree clears on the same edge; the next state is OUT.
REQ-024 OUT SHALL hold sum_valid=1 until a cycle with sum_ready=1, then go to IDLE.
REQ-025 sum_valid SHALL be registered; latency from the cfg_start edge to the first sum_valid cycle SHALL be len+3 cycles (1 cycle for len=0).
REQ-026 cfg_start outside IDLE SHALL be ignored, including in OUT in the same cycle as the sum_ready handshake.
REQ-027 abort=1 in any state SHALL force IDLE on the next edge, deassert rd_en and at_en there, and produce no sum_valid.
REQ-028 abort SHALL take priority over cfg_start and sum_ready.
REQ-029 The group counter SHALL be LEN_W bits so len=256 terminates correctly; rd_addr wraps modulo 2^ADDR_W.
REQ-030 No overflow handling is required: 256*4*255=261120 < 2^20.

Reset
REQ-031 On rst_n=0 the FSM SHALL enter IDLE.
REQ-032 On rst_n=0, rd_en, at_en, sum_valid and busy SHALL be 0, and rd_addr and sum_data SHALL be 0.
REQ-033 Reset asserted mid-operation SHALL drop all outputs to their reset values immediately, without waiting for a clock edge.

Structure
REQ-034 The FSM state encoding, ADDR_W/LEN_W defaults and the accumulator width (20) SHALL live in a shared spu_sm package.
REQ-035 The adder tree SHALL remain external; this block only sequences it.
REQ-036 The address/count generator SHALL be one sub-module, spu_sm_grp_addr_gen (load, step, last flag).

Verification
REQ-037 base=0x10, len=4, buffer groups all bytes 1 -> reads at 0x10..0x13 on consecutive cycles, at_en high 4 cycles, sum_data=16, sum_valid first at start+7.
REQ-038 base=0xFE, len=4 -> rd_addr sequence 0xFE, 0xFF, 0x00, 0x01.
REQ-039 len=256, all bytes 255 -> sum_data=261120, latency 259 cycles.
REQ-040 len=0 -> no rd_en and no at_en; sum_valid on the next cycle with sum_data=0.
REQ-041 Hold sum_ready=0 for 5 cycles with cfg_start pulsed during OUT -> sum_data stable, start ignored, IDLE after the handshake.
REQ-042 abort in FETCH at k=2 (len=8) -> IDLE next cycle, at_en=0 from the following cycle, no sum_valid; a new start then gives a correct sum starting from 0.
